// File: rtl/alu_operand_stage.sv
// alu_operand_stage: single-entry decode-to-ALU pipeline register.
// Captures one decoded instruction per input handshake. Operands are resolved
// through the EX/MEM and MEM/WB forwarding buses at the capture edge. While the
// ALU stalls, the held operands keep tracking the MEM/WB write-back bus.
module alu_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] imm,
  input  logic        use_imm,
  input  logic [5:0]  alu_control_in,
  input  logic        reg_write_in,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_data,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [5:0]  alu_control,
  output logic [4:0]  rd_out,
  output logic        reg_write_out
);

  logic        valid_q, valid_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [5:0]  alu_control_q, alu_control_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic        use_imm_q, use_imm_d;

  logic        capture;
  logic        consume;
  logic        hold;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  // Operand resolution: r0 is hard-wired, and the younger EX/MEM result wins over MEM/WB.
  function automatic logic [31:0] fwd(input logic [4:0]  addr,
                                      input logic [31:0] regdata,
                                      input logic        ex_we,
                                      input logic [4:0]  ex_rd,
                                      input logic [31:0] ex_data,
                                      input logic        wb_we,
                                      input logic [4:0]  wb_rd,
                                      input logic [31:0] wb_data);
    logic [31:0] r;
    r = regdata;
    if (addr != 5'd0) begin
      if (ex_we && ex_rd == addr)      r = ex_data;
      else if (wb_we && wb_rd == addr) r = wb_data;
    end
    return r;
  endfunction

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready;
  assign consume  = valid_q && out_ready;
  assign hold     = valid_q && !out_ready;

  // Forwarded source operands for a capture this cycle.
  always_comb begin
    rs_fwd = fwd(rs_addr, rs_data, exmem_reg_write, exmem_rd, exmem_data,
                 memwb_reg_write, memwb_rd, memwb_data);
    rt_fwd = fwd(rt_addr, rt_data, exmem_reg_write, exmem_rd, exmem_data,
                 memwb_reg_write, memwb_rd, memwb_data);
  end

  // Next-state: flush > capture > consume/snoop > hold.
  always_comb begin
    valid_d       = valid_q;
    a_d           = a_q;
    b_d           = b_q;
    alu_control_d = alu_control_q;
    rd_d          = rd_q;
    reg_write_d   = reg_write_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    use_imm_d     = use_imm_q;
    if (flush) begin
      // A same-cycle capture is a squashed younger instruction; drop it too.
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d       = 1'b1;
      a_d           = rs_fwd;
      b_d           = use_imm ? imm : rt_fwd;
      alu_control_d = alu_control_in;
      rd_d          = rd_addr;
      reg_write_d   = reg_write_in;
      rs_d          = rs_addr;
      rt_d          = rt_addr;
      use_imm_d     = use_imm;
    end else if (consume) begin
      valid_d = 1'b0;
    end else if (hold && memwb_reg_write && memwb_rd != 5'd0) begin
      // Stalled entry follows the write-back bus so it never goes stale.
      if (memwb_rd == rs_q)               a_d = memwb_data;
      if (memwb_rd == rt_q && !use_imm_q) b_d = memwb_data;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= 1'b0;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      alu_control_q <= 6'd0;
      rd_q          <= 5'd0;
      reg_write_q   <= 1'b0;
      rs_q          <= 5'd0;
      rt_q          <= 5'd0;
      use_imm_q     <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      a_q           <= a_d;
      b_q           <= b_d;
      alu_control_q <= alu_control_d;
      rd_q          <= rd_d;
      reg_write_q   <= reg_write_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      use_imm_q     <= use_imm_d;
    end
  end

  assign out_valid     = valid_q;
  assign a             = a_q;
  assign b             = b_q;
  assign alu_control   = alu_control_q;
  assign rd_out        = rd_q;
  assign reg_write_out = reg_write_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with hand-computed expected values.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data, imm;
  logic        use_imm;
  logic [5:0]  alu_control_in;
  logic        reg_write_in;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_data, memwb_data;
  logic        out_valid, out_ready;
  logic [31:0] a, b;
  logic [5:0]  alu_control;
  logic [4:0]  rd_out;
  logic        reg_write_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .use_imm(use_imm),
    .alu_control_in(alu_control_in), .reg_write_in(reg_write_in),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .alu_control(alu_control),
    .rd_out(rd_out), .reg_write_out(reg_write_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic buses_off();
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_data = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_data = 32'd0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [5:0] ctl);
    in_valid = 1'b1; rs_addr = rs; rt_addr = rt; rs_data = rsd; rt_data = rtd;
    alu_control_in = ctl; use_imm = 1'b0; imm = 32'd0; rd_addr = 5'd4; reg_write_in = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0; rs_data = 32'd0; rt_data = 32'd0;
    imm = 32'd0; use_imm = 1'b0; alu_control_in = 6'd0; reg_write_in = 1'b0;
    buses_off();
    #1;
    // Reset held for two cycles, with an instruction offered to prove reset wins.
    instr(5'd1, 5'd2, 32'd99, 32'd98, 6'h3F);
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_ctl", 32'(alu_control), 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_rw", 32'(reg_write_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single op, no forwarding.
    reset = 1'b0;
    instr(5'd1, 5'd2, 32'd5, 32'd7, 6'h20);
    tick();
    chk("op_valid", 32'(out_valid), 32'd1);
    chk("op_a", a, 32'd5);
    chk("op_b", b, 32'd7);
    chk("op_ctl", 32'(alu_control), 32'h20);
    chk("op_rd", 32'(rd_out), 32'd4);
    chk("op_rw", 32'(reg_write_out), 32'd1);

    // Forwarding priority: EX/MEM beats MEM/WB.
    instr(5'd3, 5'd2, 32'd11, 32'd22, 6'h01);
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_data = 32'hAAAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_data = 32'hBBBB;
    tick();
    chk("fwd_ex_a", a, 32'hAAAA);
    chk("fwd_ex_b", b, 32'd22);
    // MEM/WB only.
    exmem_reg_write = 1'b0;
    tick();
    chk("fwd_wb_a", a, 32'hBBBB);
    // r0 is never forwarded.
    instr(5'd0, 5'd2, 32'd33, 32'd22, 6'h01);
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    tick();
    chk("fwd_r0_a", a, 32'd33);

    // rt forwarding, then immediate path ignoring it.
    instr(5'd1, 5'd6, 32'd1, 32'd2, 6'h02);
    exmem_reg_write = 1'b1; exmem_rd = 5'd6; exmem_data = 32'hCAFE;
    memwb_reg_write = 1'b0;
    tick();
    chk("fwd_rt_b", b, 32'hCAFE);
    use_imm = 1'b1; imm = 32'hFFFF_FFF0;
    tick();
    chk("imm_b", b, 32'hFFFF_FFF0);

    // Stall with snoop: held rs = 9, rt = 10.
    buses_off();
    instr(5'd9, 5'd10, 32'd100, 32'd200, 6'h05);
    tick();
    chk("stall_cap_a", a, 32'd100);
    instr(5'd11, 5'd12, 32'd999, 32'd888, 6'h06);
    out_ready = 1'b0;
    #1;
    chk("stall1_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("stall1_a", a, 32'd100);
    memwb_reg_write = 1'b1; memwb_rd = 5'd9; memwb_data = 32'h1234;
    #1;
    chk("stall2_in_ready", 32'(in_ready), 32'd0);
    chk("stall2_a_pre", a, 32'd100);
    tick();
    chk("stall2_a", a, 32'h1234);
    chk("stall2_b", b, 32'd200);
    memwb_reg_write = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd9; exmem_data = 32'hDEAD;
    #1;
    chk("stall3_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("stall3_a", a, 32'h1234);
    chk("stall3_valid", 32'(out_valid), 32'd1);
    chk("stall3_ctl", 32'(alu_control), 32'h05);
    buses_off();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("consumed_valid", 32'(out_valid), 32'd0);
    chk("consumed_a_kept", a, 32'h1234);

    // Back-to-back streaming.
    for (int i = 0; i < 4; i++) begin
      instr(5'd1, 5'd2, 32'h10 + 32'(i), 32'h20 + 32'(i), 6'(i + 8));
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_a", a, 32'h10 + 32'(i));
      chk("stream_ctl", 32'(alu_control), 32'(i + 8));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", 32'(out_valid), 32'd0);

    // Flush with an entry held and a same-cycle capture.
    instr(5'd1, 5'd2, 32'h55, 32'h56, 6'h07);
    out_ready = 1'b0;
    tick();
    chk("flush_held", 32'(out_valid), 32'd1);
    instr(5'd1, 5'd2, 32'h66, 32'h67, 6'h08);
    out_ready = 1'b1; flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid1", 32'(out_valid), 32'd0);
    tick();
    chk("flush_valid2", 32'(out_valid), 32'd0);

    // Reset during a held stall drops the entry.
    instr(5'd1, 5'd2, 32'h77, 32'h78, 6'h09);
    out_ready = 1'b0;
    tick();
    chk("midrst_held", 32'(out_valid), 32'd1);
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_a", a, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
